// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the stage registers.
// Holds the FSM state encoding, the packed pipeline-control word with its
// canonical values (including the NOP/bubble word the stage registers load),
// and a saturating increment helper for the memory-wait counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // One bit per pipeline control output, in port order.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam int WAIT_W = 8;

  // Normal flow: every register advances, nothing squashed.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                 idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1,
                                 memwb_bubble: 1'b0};
  // NOP/bubble word: PC held, every stage register loads zeroed control.
  localparam ctrl_t CTRL_NOP = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                 idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1,
                                 memwb_bubble: 1'b1};
  // Data-memory wait: front of pipe frozen, MEM/WB fed bubbles.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_write: 1'b0, idex_bubble: 1'b0, exmem_write: 1'b0,
                                    memwb_bubble: 1'b1};
  // Taken redirect: PC loads target, IF and ID wrong-path work squashed.
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1,
                                      memwb_bubble: 1'b0};
  // Extra wrong-path slot after a redirect: only IF/ID is squashed.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1,
                                   memwb_bubble: 1'b0};
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LOADUSE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1,
                                     memwb_bubble: 1'b0};

  function automatic logic [WAIT_W-1:0] sat_inc8(input logic [WAIT_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Performance counters and memory-wait watchdog for the hazard controller.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   i_stall           PC held this cycle
//   i_redirect        taken redirect accepted this cycle
//   i_frozen          pipeline frozen on a data-memory wait this cycle
//   i_in_wait         FSM is already in MEMWAIT (continuing, not entering)
//   o_stall_cycles    wrapping count of PC-held cycles
//   o_flush_count     wrapping count of accepted redirects
//   o_mem_timeout     sticky flag: wait count reached MAX_WAIT
module hazard_perf_counters
  import hazard_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic             i_frozen,
  input  logic             i_in_wait,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_mem_timeout;

  // Wait count: 1 on the first frozen cycle, saturating step while waiting, 0 otherwise.
  always_comb begin
    w_wait_next = 8'd0;
    if (i_frozen) begin
      if (i_in_wait) begin
        w_wait_next = sat_inc8(r_wait);
      end else begin
        w_wait_next = 8'd1;
      end
    end else begin
      w_wait_next = 8'd0;
    end
  end

  // Counter and watchdog registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wait         <= 8'd0;
      r_mem_timeout  <= 1'b0;
    end else begin
      if (i_stall) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
      if (i_redirect) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
      r_wait <= w_wait_next;
      if (i_frozen && (w_wait_next >= WAIT_MAX)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
  assign o_mem_timeout  = r_mem_timeout;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage SAD datapath.
// Decodes memory-wait, redirect and load-use hazards (in that priority) and
// drives the pipeline-register enables and squash controls combinationally
// from the FSM state (RUN / MEMWAIT / FLUSH) and the current inputs.
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_UsesRt       source operands of the ID instruction
//   EX_MemRead, EX_WriteReg       load indicator / destination in EX
//   MEM_Access, MemReady          data-memory access and completion
//   BranchTaken                   EX redirects the PC this cycle
//   PCWrite .. MEMWBBubble        pipeline register controls
//   StallCycles, FlushCount       performance counters
//   MemTimeout                    sticky memory-wait watchdog
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int FLUSH_SLOTS = 1,
  parameter int MAX_WAIT    = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteReg,
  input  logic             MEM_Access,
  input  logic             MemReady,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMWrite,
  output logic             MEMWBBubble,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_SLOTS - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_next;
  ctrl_t      w_ctrl;
  logic       w_memstall;
  logic       w_loaduse;
  logic       w_resume_flush;
  logic       w_redirect_acc;

  assign w_memstall = MEM_Access & ~MemReady;
  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_loaduse  = EX_MemRead & (EX_WriteReg != '0) &
                      ((EX_WriteReg == ID_Rs) | (ID_UsesRt & (EX_WriteReg == ID_Rt)));
  // A flush interrupted by a memory wait picks up again on the release cycle.
  assign w_resume_flush = (r_state == ST_FLUSH) ||
                          ((r_state == ST_MEMWAIT) && (r_flush_cnt != 3'd0));

  // Event priority decode: controls, next state and flush-slot counter.
  always_comb begin
    w_ctrl         = CTRL_RUN;
    w_state_next   = ST_RUN;
    w_flush_next   = r_flush_cnt;
    w_redirect_acc = 1'b0;
    if (Rst) begin
      w_ctrl       = CTRL_NOP;
      w_state_next = ST_RUN;
      w_flush_next = 3'd0;
    end else if (w_memstall) begin
      w_ctrl       = CTRL_FREEZE;
      w_state_next = ST_MEMWAIT;
    end else if (BranchTaken) begin
      w_ctrl         = CTRL_REDIRECT;
      w_redirect_acc = 1'b1;
      if (FLUSH_SLOTS > 1) begin
        w_state_next = ST_FLUSH;
        w_flush_next = FLUSH_RELOAD;
      end else begin
        w_state_next = ST_RUN;
        w_flush_next = 3'd0;
      end
    end else if (w_resume_flush) begin
      // ID already holds a squashed NOP here, so load-use is irrelevant.
      w_ctrl = CTRL_FLUSH;
      if (r_flush_cnt <= 3'd1) begin
        w_state_next = ST_RUN;
        w_flush_next = 3'd0;
      end else begin
        w_state_next = ST_FLUSH;
        w_flush_next = r_flush_cnt - 3'd1;
      end
    end else if (w_loaduse) begin
      w_ctrl       = CTRL_LOADUSE;
      w_state_next = ST_RUN;
    end else begin
      w_ctrl       = CTRL_RUN;
      w_state_next = ST_RUN;
    end
  end

  // FSM state and flush-slot counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_next;
    end
  end

  hazard_perf_counters #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_perf (
    .Clk            (Clk),
    .Rst            (Rst),
    .i_stall        (~w_ctrl.pc_write),
    .i_redirect     (w_redirect_acc),
    .i_frozen       (w_memstall),
    .i_in_wait      (r_state == ST_MEMWAIT),
    .o_stall_cycles (StallCycles),
    .o_flush_count  (FlushCount),
    .o_mem_timeout  (MemTimeout)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign IFIDWrite   = w_ctrl.ifid_write;
  assign IFIDFlush   = w_ctrl.ifid_flush;
  assign IDEXWrite   = w_ctrl.idex_write;
  assign IDEXBubble  = w_ctrl.idex_bubble;
  assign EXMEMWrite  = w_ctrl.exmem_write;
  assign MEMWBBubble = w_ctrl.memwb_bubble;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (FLUSH_SLOTS=2, MAX_WAIT=15).
// Expected control words are queued as each cycle's inputs are applied and
// compared at the following falling edge; counters are checked after edges.
module tb_pipeline_hazard_controller;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble}
  localparam logic [6:0] E_RUN    = 7'b1101010;
  localparam logic [6:0] E_RESET  = 7'b0011111;
  localparam logic [6:0] E_FREEZE = 7'b0000001;
  localparam logic [6:0] E_REDIR  = 7'b1111110;
  localparam logic [6:0] E_FLUSH  = 7'b1111010;
  localparam logic [6:0] E_LDUSE  = 7'b0001110;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRt, EX_MemRead, MEM_Access, MemReady, BranchTaken;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble;
  logic [31:0] StallCycles, FlushCount;
  logic        MemTimeout;

  int n_cmp = 0;
  int n_bad = 0;
  string      tag_q[$];
  logic [6:0] exp_q[$];

  pipeline_hazard_controller #(
    .REG_W(5), .CNT_W(32), .FLUSH_SLOTS(2), .MAX_WAIT(15)
  ) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .MEM_Access(MEM_Access),
    .MemReady(MemReady), .BranchTaken(BranchTaken), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXWrite(IDEXWrite),
    .IDEXBubble(IDEXBubble), .EXMEMWrite(EXMEMWrite), .MEMWBBubble(MEMWBBubble),
    .StallCycles(StallCycles), .FlushCount(FlushCount), .MemTimeout(MemTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic memread, input logic [4:0] wreg,
                        input logic access, input logic ready, input logic br);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses_rt; EX_MemRead = memread;
    EX_WriteReg = wreg; MEM_Access = access; MemReady = ready; BranchTaken = br;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Queue the expected control word for the current inputs, then advance one cycle.
  task automatic cyc(input string tag, input logic [6:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
  endtask

  // Compare the combinational controls mid-cycle against the queued expectation.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(),
            {25'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble},
            {25'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Rst = 1'b1;
    idle();
    @(posedge Clk); #1;
    cyc("rst_ctrl", E_RESET);
    cyc("rst_ctrl2", E_RESET);
    check("rst_stall", StallCycles, 32'd0);
    check("rst_flush", FlushCount, 32'd0);
    check("rst_tmo", {31'd0, MemTimeout}, 32'd0);
    Rst = 1'b0;
    cyc("idle", E_RUN);
    check("idle_stall", StallCycles, 32'd0);

    // Load-use through rs, then through rt, then rt not used.
    set_in(5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    cyc("ldu_rs", E_LDUSE);
    idle();
    cyc("ldu_after", E_RUN);
    check("ldu_stall", StallCycles, 32'd1);
    set_in(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    cyc("ldu_rt", E_LDUSE);
    set_in(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    cyc("ldu_rt_unused", E_RUN);
    // Register-0 destination never stalls.
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("ldu_r0", E_RUN);
    check("r0_stall", StallCycles, 32'd2);

    // Taken branch: two squashed IF/ID cycles, PC keeps loading.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("br_redir", E_REDIR);
    idle();
    cyc("br_flush", E_FLUSH);
    cyc("br_done", E_RUN);
    check("br_count", FlushCount, 32'd1);
    check("br_stall", StallCycles, 32'd2);

    // Branch and load-use together: redirect wins.
    set_in(5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
    cyc("br_ldu", E_REDIR);
    idle();
    cyc("br_ldu_flush", E_FLUSH);
    check("br_ldu_count", FlushCount, 32'd2);

    // Four-cycle memory wait.
    for (int i = 0; i < 4; i++) begin
      set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc("mw_freeze", E_FREEZE);
    end
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("mw_release", E_RUN);
    idle();
    check("mw_stall", StallCycles, 32'd6);
    check("mw_tmo", {31'd0, MemTimeout}, 32'd0);

    // Memory wait inside a flush: remaining slot resumes after release.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("fm_redir", E_REDIR);
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("fm_freeze1", E_FREEZE);
    cyc("fm_freeze2", E_FREEZE);
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("fm_resume", E_FLUSH);
    idle();
    cyc("fm_done", E_RUN);
    check("fm_count", FlushCount, 32'd3);
    check("fm_stall", StallCycles, 32'd8);

    // New redirect during flush reloads and counts.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("rr_redir1", E_REDIR);
    cyc("rr_redir2", E_REDIR);
    idle();
    cyc("rr_flush", E_FLUSH);
    cyc("rr_done", E_RUN);
    check("rr_count", FlushCount, 32'd5);

    // Long wait: timeout sets once the wait count reaches 15 and stays.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc("to_freeze", E_FREEZE);
      if (i == 14) check("to_before", {31'd0, MemTimeout}, 32'd0);
      if (i == 15) check("to_set", {31'd0, MemTimeout}, 32'd1);
    end
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("to_release", E_RUN);
    idle();
    cyc("to_idle", E_RUN);
    check("to_sticky", {31'd0, MemTimeout}, 32'd1);
    check("to_stall", StallCycles, 32'd28);

    // Reset during MEMWAIT.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("rm_freeze1", E_FREEZE);
    cyc("rm_freeze2", E_FREEZE);
    Rst = 1'b1;
    cyc("rm_rst", E_RESET);
    Rst = 1'b0;
    check("rm_stall", StallCycles, 32'd0);
    check("rm_flush", FlushCount, 32'd0);
    check("rm_tmo", {31'd0, MemTimeout}, 32'd0);
    idle();
    cyc("rm_run", E_RUN);

    // Reset during FLUSH.
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("rf_redir", E_REDIR);
    idle();
    Rst = 1'b1;
    cyc("rf_rst", E_RESET);
    Rst = 1'b0;
    cyc("rf_run", E_RUN);
    check("rf_flush", FlushCount, 32'd0);

    @(negedge Clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
